// File: rtl/plab2_mem_sec_scratchpad_resp_if.sv
// Request/response bus of the secure scratchpad: request channel with the
// requester's security domain, and the buffered response channel.
interface plab2_mem_sec_scratchpad_resp_if;
   logic        req_domain;
   logic [76:0] memreq_msg;
   logic        memreq_val;
   logic        memreq_rdy;
   logic [44:0] memresp_msg;
   logic        memresp_val;
   logic        memresp_rdy;

   modport master (
      output req_domain, memreq_msg, memreq_val, memresp_rdy,
      input  memreq_rdy, memresp_msg, memresp_val
   );

   modport slave (
      input  req_domain, memreq_msg, memreq_val, memresp_rdy,
      output memreq_rdy, memresp_msg, memresp_val
   );
endinterface

// File: rtl/plab2_mem_sec_scratchpad_resp.sv
// Word scratchpad with a secure upper region: normal-domain accesses to it are
// rejected (writes dropped, reads return 0) and counted. Responses go through a 2-entry FIFO.
module plab2_mem_sec_scratchpad_resp #(
   parameter int p_num_words = 256,
   parameter int p_sec_base  = 128
) (
   input  logic                          clk,
   input  logic                          reset,
   plab2_mem_sec_scratchpad_resp_if.slave bus,
   output logic                          viol_pulse,
   output logic [15:0]                   viol_count
);

   localparam int idx_w = $clog2(p_num_words);
   localparam logic [idx_w:0] sec_base = p_sec_base[idx_w:0];

   logic [2:0]       req_type;
   logic [7:0]       req_opaque;
   logic [31:0]      req_addr;
   logic [1:0]       req_len;
   logic [31:0]      req_data;
   logic [idx_w-1:0] idx;
   logic             viol;
   logic             accept;
   logic             deq;
   logic             do_write;
   logic [31:0]      rd_data;
   logic [44:0]      resp_next;
   logic             unused_addr;

   logic [31:0] mem [p_num_words];
   logic [44:0] fifo_q [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;

   assign req_type   = bus.memreq_msg[76:74];
   assign req_opaque = bus.memreq_msg[73:66];
   assign req_addr   = bus.memreq_msg[65:34];
   assign req_len    = bus.memreq_msg[33:32];
   assign req_data   = bus.memreq_msg[31:0];

   // Upper address bits wrap and the byte offset is ignored.
   assign idx         = req_addr[idx_w+1:2];
   assign unused_addr = ^{req_addr[31:idx_w+2], req_addr[1:0]};

   assign viol     = !bus.req_domain && ({1'b0, idx} >= sec_base);
   assign accept   = bus.memreq_val && bus.memreq_rdy;
   assign deq      = bus.memresp_val && bus.memresp_rdy;
   assign do_write = accept && (req_type == 3'd1) && !viol;

   // Writes, rejected accesses and unknown types all answer with data 0.
   assign rd_data   = (viol || (req_type != 3'd0)) ? 32'd0 : mem[idx];
   assign resp_next = {req_type, req_opaque, req_len, rd_data};

   assign bus.memreq_rdy  = !reset && (count != 2'd2);
   assign bus.memresp_val = !reset && (count != 2'd0);
   assign bus.memresp_msg = fifo_q[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < p_num_words; i++) begin
            mem[i] <= '0;
         end
      end else if (do_write) begin
         mem[idx] <= req_data;
      end
   end

   // Response payload storage needs no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (accept) begin
         fifo_q[wr_ptr] <= resp_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (accept) begin
            wr_ptr <= ~wr_ptr;
         end
         if (deq) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({accept, deq})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         viol_pulse <= 1'b0;
         viol_count <= 16'd0;
      end else begin
         viol_pulse <= accept && viol;
         if (accept && viol && (viol_count != 16'hFFFF)) begin
            viol_count <= viol_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_plab2_mem_sec_scratchpad_resp.sv
// Directed bench for the secure scratchpad: domain checks, wrap-around,
// response FIFO backpressure, streaming and mid-operation reset.
module tb_plab2_mem_sec_scratchpad_resp;

   logic        clk;
   logic        reset;
   logic        viol_pulse;
   logic [15:0] viol_count;
   int          total;
   int          bad;

   plab2_mem_sec_scratchpad_resp_if bus ();

   plab2_mem_sec_scratchpad_resp #(
      .p_num_words(256),
      .p_sec_base (128)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .viol_pulse(viol_pulse),
      .viol_count(viol_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                          input logic [31:0] addr, input logic [1:0] len,
                                          input logic [31:0] data);
      return {t, op, addr, len, data};
   endfunction

   function automatic logic [44:0] mk_resp(input logic [2:0] t, input logic [7:0] op,
                                           input logic [1:0] len, input logic [31:0] data);
      return {t, op, len, data};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic val, input logic dom, input logic [76:0] msg);
      bus.memreq_val = val;
      bus.req_domain = dom;
      bus.memreq_msg = msg;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, '0);
      bus.memresp_rdy = 1'b1;
      step();
      step();
      total++;
      if (bus.memreq_rdy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_rdy: got %b expected 0", bus.memreq_rdy);
      end
      total++;
      if (bus.memresp_val !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_val: got %b expected 0", bus.memresp_val);
      end
      total++;
      if (viol_pulse !== 1'b0 || viol_count !== 16'd0) begin
         bad++;
         $display("[TB] FAIL reset_viol: got pulse=%b count=%0d expected 0/0", viol_pulse, viol_count);
      end
      reset = 1'b0;
      step();
      total++;
      if (bus.memreq_rdy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL post_reset_rdy: got %b expected 1", bus.memreq_rdy);
      end
   endtask

   task automatic test_secure_rw();
      applyStimulus(1'b1, 1'b1, mk_req(3'd1, 8'h11, 32'h204, 2'd0, 32'hDEADBEEF));
      total++;
      if (bus.memreq_rdy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL srw_rdy: got %b expected 1", bus.memreq_rdy);
      end
      step();
      applyStimulus(1'b1, 1'b1, mk_req(3'd0, 8'h22, 32'h204, 2'd2, 32'h0));
      total++;
      if (bus.memresp_val !== 1'b1 || bus.memresp_msg !== mk_resp(3'd1, 8'h11, 2'd0, 32'd0)) begin
         bad++;
         $display("[TB] FAIL srw_wr_resp: got val=%b msg=%h expected 1/%h", bus.memresp_val,
                  bus.memresp_msg, mk_resp(3'd1, 8'h11, 2'd0, 32'd0));
      end
      step();
      applyStimulus(1'b0, 1'b1, '0);
      total++;
      if (bus.memresp_val !== 1'b1 || bus.memresp_msg !== mk_resp(3'd0, 8'h22, 2'd2, 32'hDEADBEEF)) begin
         bad++;
         $display("[TB] FAIL srw_rd_resp: got val=%b msg=%h expected 1/%h", bus.memresp_val,
                  bus.memresp_msg, mk_resp(3'd0, 8'h22, 2'd2, 32'hDEADBEEF));
      end
      step();
      total++;
      if (bus.memresp_val !== 1'b0) begin
         bad++;
         $display("[TB] FAIL srw_drain: got val=%b expected 0", bus.memresp_val);
      end
   endtask

   task automatic test_violation();
      applyStimulus(1'b1, 1'b0, mk_req(3'd1, 8'h33, 32'h200, 2'd0, 32'h1234));
      step();
      applyStimulus(1'b1, 1'b1, mk_req(3'd0, 8'h44, 32'h200, 2'd0, 32'h0));
      total++;
      if (viol_pulse !== 1'b1 || viol_count !== 16'd1) begin
         bad++;
         $display("[TB] FAIL viol_first: got pulse=%b count=%0d expected 1/1", viol_pulse, viol_count);
      end
      total++;
      if (bus.memresp_msg !== mk_resp(3'd1, 8'h33, 2'd0, 32'd0)) begin
         bad++;
         $display("[TB] FAIL viol_wr_resp: got %h expected %h", bus.memresp_msg,
                  mk_resp(3'd1, 8'h33, 2'd0, 32'd0));
      end
      step();
      total++;
      if (viol_pulse !== 1'b0 || viol_count !== 16'd1) begin
         bad++;
         $display("[TB] FAIL viol_one_cycle: got pulse=%b count=%0d expected 0/1", viol_pulse, viol_count);
      end
      total++;
      if (bus.memresp_msg !== mk_resp(3'd0, 8'h44, 2'd0, 32'd0)) begin
         bad++;
         $display("[TB] FAIL viol_dropped: got %h expected %h", bus.memresp_msg,
                  mk_resp(3'd0, 8'h44, 2'd0, 32'd0));
      end
      // Two back-to-back normal reads of the top secure word.
      applyStimulus(1'b1, 1'b0, mk_req(3'd0, 8'h45, 32'h3FC, 2'd0, 32'h0));
      step();
      applyStimulus(1'b1, 1'b0, mk_req(3'd0, 8'h46, 32'h3FC, 2'd0, 32'h0));
      step();
      total++;
      if (viol_pulse !== 1'b1 || viol_count !== 16'd3) begin
         bad++;
         $display("[TB] FAIL viol_b2b: got pulse=%b count=%0d expected 1/3", viol_pulse, viol_count);
      end
      // Index 127 is the last normal word.
      applyStimulus(1'b1, 1'b0, mk_req(3'd1, 8'h47, 32'h1FC, 2'd0, 32'hA5A5));
      step();
      total++;
      if (viol_pulse !== 1'b0 || viol_count !== 16'd3) begin
         bad++;
         $display("[TB] FAIL viol_boundary_wr: got pulse=%b count=%0d expected 0/3", viol_pulse, viol_count);
      end
      applyStimulus(1'b1, 1'b0, mk_req(3'd0, 8'h48, 32'h1FC, 2'd1, 32'h0));
      step();
      applyStimulus(1'b0, 1'b1, '0);
      total++;
      if (bus.memresp_msg !== mk_resp(3'd0, 8'h48, 2'd1, 32'hA5A5) || viol_pulse !== 1'b0) begin
         bad++;
         $display("[TB] FAIL viol_boundary_rd: got %h pulse=%b expected %h pulse=0", bus.memresp_msg,
                  viol_pulse, mk_resp(3'd0, 8'h48, 2'd1, 32'hA5A5));
      end
      step();
   endtask

   task automatic test_other_type();
      applyStimulus(1'b1, 1'b1, mk_req(3'd2, 8'h50, 32'h8, 2'd3, 32'hFFFF0000));
      step();
      applyStimulus(1'b1, 1'b1, mk_req(3'd0, 8'h51, 32'h8, 2'd0, 32'h0));
      total++;
      if (bus.memresp_msg !== mk_resp(3'd2, 8'h50, 2'd3, 32'd0)) begin
         bad++;
         $display("[TB] FAIL other_resp: got %h expected %h", bus.memresp_msg,
                  mk_resp(3'd2, 8'h50, 2'd3, 32'd0));
      end
      step();
      applyStimulus(1'b0, 1'b1, '0);
      total++;
      if (bus.memresp_msg !== mk_resp(3'd0, 8'h51, 2'd0, 32'd0)) begin
         bad++;
         $display("[TB] FAIL other_no_write: got %h expected %h", bus.memresp_msg,
                  mk_resp(3'd0, 8'h51, 2'd0, 32'd0));
      end
      step();
   endtask

   task automatic test_back_to_back();
      bus.memresp_rdy = 1'b0;
      applyStimulus(1'b1, 1'b1, mk_req(3'd0, 8'h01, 32'h204, 2'd0, 32'h0));
      step();
      applyStimulus(1'b1, 1'b1, mk_req(3'd0, 8'h02, 32'h1FC, 2'd0, 32'h0));
      step();
      applyStimulus(1'b1, 1'b1, mk_req(3'd0, 8'h03, 32'h204, 2'd1, 32'h0));
      total++;
      if (bus.memreq_rdy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL bp_full_rdy: got %b expected 0", bus.memreq_rdy);
      end
      step();
      step();
      total++;
      if (bus.memresp_val !== 1'b1 || bus.memresp_msg !== mk_resp(3'd0, 8'h01, 2'd0, 32'hDEADBEEF)) begin
         bad++;
         $display("[TB] FAIL bp_hold: got val=%b msg=%h expected 1/%h", bus.memresp_val,
                  bus.memresp_msg, mk_resp(3'd0, 8'h01, 2'd0, 32'hDEADBEEF));
      end
      bus.memresp_rdy = 1'b1;
      step();
      total++;
      if (bus.memresp_msg !== mk_resp(3'd0, 8'h02, 2'd0, 32'hA5A5) || bus.memreq_rdy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL bp_second: got %h rdy=%b expected %h rdy=1", bus.memresp_msg,
                  bus.memreq_rdy, mk_resp(3'd0, 8'h02, 2'd0, 32'hA5A5));
      end
      step();
      applyStimulus(1'b0, 1'b1, '0);
      total++;
      if (bus.memresp_msg !== mk_resp(3'd0, 8'h03, 2'd1, 32'hDEADBEEF)) begin
         bad++;
         $display("[TB] FAIL bp_third: got %h expected %h", bus.memresp_msg,
                  mk_resp(3'd0, 8'h03, 2'd1, 32'hDEADBEEF));
      end
      step();
      total++;
      if (bus.memresp_val !== 1'b0) begin
         bad++;
         $display("[TB] FAIL bp_drain: got val=%b expected 0", bus.memresp_val);
      end
   endtask

   task automatic test_stream();
      logic [31:0] addrs [4];
      logic [31:0] datas [4];
      addrs = '{32'h204, 32'h1FC, 32'h200, 32'h3FC};
      datas = '{32'hDEADBEEF, 32'hA5A5, 32'h0, 32'h0};
      bus.memresp_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, mk_req(3'd0, 8'h60 + 8'(i), addrs[i], 2'd0, 32'h0));
         step();
         total++;
         if (bus.memresp_val !== 1'b1 || bus.memreq_rdy !== 1'b1 ||
             bus.memresp_msg !== mk_resp(3'd0, 8'h60 + 8'(i), 2'd0, datas[i])) begin
            bad++;
            $display("[TB] FAIL stream_%0d: got val=%b rdy=%b msg=%h expected 1/1/%h", i,
                     bus.memresp_val, bus.memreq_rdy, bus.memresp_msg,
                     mk_resp(3'd0, 8'h60 + 8'(i), 2'd0, datas[i]));
         end
      end
      applyStimulus(1'b0, 1'b1, '0);
      step();
   endtask

   task automatic test_wrap();
      applyStimulus(1'b1, 1'b0, mk_req(3'd1, 8'h70, 32'h400, 2'd0, 32'h55));
      step();
      applyStimulus(1'b1, 1'b1, mk_req(3'd0, 8'h71, 32'h0, 2'd0, 32'h0));
      total++;
      if (viol_pulse !== 1'b0 || viol_count !== 16'd3) begin
         bad++;
         $display("[TB] FAIL wrap_viol: got pulse=%b count=%0d expected 0/3", viol_pulse, viol_count);
      end
      step();
      applyStimulus(1'b0, 1'b1, '0);
      total++;
      if (bus.memresp_msg !== mk_resp(3'd0, 8'h71, 2'd0, 32'h55)) begin
         bad++;
         $display("[TB] FAIL wrap_read: got %h expected %h", bus.memresp_msg,
                  mk_resp(3'd0, 8'h71, 2'd0, 32'h55));
      end
      step();
   endtask

   task automatic test_reset_mid();
      bus.memresp_rdy = 1'b0;
      applyStimulus(1'b1, 1'b1, mk_req(3'd0, 8'h80, 32'h204, 2'd0, 32'h0));
      step();
      step();
      applyStimulus(1'b0, 1'b1, '0);
      total++;
      if (bus.memresp_val !== 1'b1 || bus.memreq_rdy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rmid_full: got val=%b rdy=%b expected 1/0", bus.memresp_val, bus.memreq_rdy);
      end
      reset = 1'b1;
      step();
      total++;
      if (bus.memresp_val !== 1'b0 || viol_count !== 16'd0) begin
         bad++;
         $display("[TB] FAIL rmid_flush: got val=%b count=%0d expected 0/0", bus.memresp_val, viol_count);
      end
      reset = 1'b0;
      bus.memresp_rdy = 1'b1;
      applyStimulus(1'b1, 1'b1, mk_req(3'd0, 8'h81, 32'h204, 2'd0, 32'h0));
      step();
      applyStimulus(1'b1, 1'b1, mk_req(3'd0, 8'h82, 32'h0, 2'd0, 32'h0));
      total++;
      if (bus.memresp_val !== 1'b1 || bus.memresp_msg !== mk_resp(3'd0, 8'h81, 2'd0, 32'd0)) begin
         bad++;
         $display("[TB] FAIL rmid_cleared_204: got val=%b msg=%h expected 1/%h", bus.memresp_val,
                  bus.memresp_msg, mk_resp(3'd0, 8'h81, 2'd0, 32'd0));
      end
      step();
      applyStimulus(1'b0, 1'b1, '0);
      total++;
      if (bus.memresp_msg !== mk_resp(3'd0, 8'h82, 2'd0, 32'd0)) begin
         bad++;
         $display("[TB] FAIL rmid_cleared_0: got %h expected %h", bus.memresp_msg,
                  mk_resp(3'd0, 8'h82, 2'd0, 32'd0));
      end
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_secure_rw();
      test_violation();
      test_other_type();
      test_back_to_back();
      test_stream();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/plab2_mem_sec_scratchpad_resp.md
PLAB2_MEM_SEC_SCRATCHPAD_RESP -- requirements
Module: plab2_mem_SecScratchpadResp

Interface
REQ-001 SHALL have parameter p_num_words, default 256, meaning scratchpad depth in 32-bit words (power of two).
REQ-002 SHALL have parameter p_sec_base, default 128, meaning first word index of the secure region; indices >= p_sec_base are secure.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_domain  input  1  domain of the current requester (1 = secure, 0 = normal), sampled with the request.
REQ-006 SHALL have port memreq_msg  input  77  request: [76:74] type, [73:66] opaque, [65:34] addr, [33:32] len, [31:0] data.
REQ-007 SHALL have port memreq_val  input  1  request valid.
REQ-008 SHALL have port memreq_rdy  output  1  request ready.
REQ-009 SHALL have port memresp_msg  output  45  response: [44:42] type, [41:34] opaque, [33:32] len, [31:0] data.
REQ-010 SHALL have port memresp_val  output  1  response valid.
REQ-011 SHALL have port memresp_rdy  input  1  response ready.
REQ-012 SHALL have port viol_pulse  output  1  one-cycle flag for a rejected access.
REQ-013 SHALL have port viol_count  output  16  saturating count of rejected accesses.

Function
REQ-014 SHALL accept a request only on a cycle where memreq_val and memreq_rdy are both 1; the response-producing transfer occurs only when memresp_val and memresp_rdy are both 1.
REQ-015 SHALL compute word index = addr[2+log2(p_num_words)-1 : 2]; higher address bits are ignored (wrap-around); addr[1:0] ignored.
REQ-016 SHALL treat type 0 as read and type 1 as write; other types behave as read returning data 0 with no memory effect.
REQ-017 SHALL flag a violation when req_domain = 0 and index >= p_sec_base; secure requesters access every index.
REQ-018 SHALL, for a permitted write, commit data to the word at the accept edge; response data = 0.
REQ-019 SHALL, for a permitted read, return the word contents as of the accept edge, including a write accepted on the immediately preceding cycle.
REQ-020 SHALL, for a violating access, drop writes, return data 0 for reads, and still return a response.
REQ-021 SHALL echo type, opaque and len of the request unchanged in the response.
REQ-022 SHALL buffer responses in a 2-entry FIFO; response written at accept edge, memresp_val high the cycle after acceptance (latency 1), strict order preserved.
REQ-023 SHALL drive memreq_rdy = 1 iff FIFO occupancy < 2, independent of memresp_rdy (no bypass); occupancy 1 with simultaneous enq and deq stays 1, sustaining one request per cycle.
REQ-024 SHALL drive memresp_val = 1 iff occupancy > 0; memresp_msg SHALL hold stable while val=1 and rdy=0.
REQ-025 SHALL assert viol_pulse for exactly the cycle after each violating accept; back-to-back violations keep it high continuously.
REQ-026 SHALL increment viol_count by 1 per violating accept, saturating at 16'hFFFF.

Reset
REQ-027 SHALL, while reset=1, hold memreq_rdy=0, memresp_val=0, viol_pulse=0, viol_count=0, FIFO empty, all memory words cleared to 0.
REQ-028 SHALL discard any buffered or in-flight response when reset asserts mid-operation; writes accepted before the reset edge are cleared.
REQ-029 SHALL assert memreq_rdy=1 on the first cycle after reset deasserts.

Verification
REQ-030 SHALL cover: secure write addr 0x204 data 0xDEADBEEF, secure read 0x204 next cycle -> read response data 0xDEADBEEF, opaque echoed, latency 1.
REQ-031 SHALL cover: normal-domain write 0x200 (index 128) data 0x1234 then secure read 0x200 -> data 0, viol_pulse high one cycle, viol_count=1.
REQ-032 SHALL cover: memresp_rdy=0 with three back-to-back requests -> two accepted, memreq_rdy=0 on third, resume in order after memresp_rdy=1.
REQ-033 SHALL cover: continuous reads with memresp_rdy=1 -> one response per cycle, occupancy never exceeds 1.
REQ-034 SHALL cover: normal-domain write addr 0x400 (wraps to index 0) data 0x55 -> secure read 0x0 returns 0x55, no violation.
REQ-035 SHALL cover: reset asserted with 2 responses buffered -> memresp_val=0 next cycle, subsequent read of previously written word returns 0.
